// File: rtl/text_console_ctrl.sv
// text_console_ctrl
// Command-driven write controller for the text RAM write port of the text
// pixel generator. Host commands (put char, newline, home, clear) arrive over
// a valid/ready handshake. The controller keeps a cursor and issues at most
// one registered text RAM write per cycle. CLEAR runs a multi-cycle fill of
// the whole screen and blocks new commands until it completes.
//
// Ports:
//   clk           system clock, also the text RAM write clock
//   reset         synchronous, active-high reset
//   cmd_valid     command present
//   cmd_ready     controller accepts a command this cycle (low while filling)
//   cmd_op        0=PUT_CHAR, 1=NEWLINE, 2=CLEAR, 3=HOME
//   cmd_data      glyph for PUT_CHAR, fill glyph for CLEAR
//   text_wr_ena   one-cycle write strobe
//   text_wr_data  write data
//   text_wr_addr  write address (row*TEXT_WIDTH + col)
//   cursor_col    current cursor column
//   cursor_row    current cursor row
//   busy          high while a CLEAR fill is running
//
// Optional feature macro: TEXT_CONSOLE_CTRL_ASCII_EN
//   When defined, PUT_CHAR interprets 0x0A (newline), 0x0D (carriage return)
//   and 0x0C (form feed = clear with spaces). When undefined every code is
//   written literally, since the font covers the full code page 437.
module text_console_ctrl #(
  parameter int TEXT_WIDTH  = 60,
  parameter int TEXT_HEIGHT = 20,
  parameter int TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT,
  parameter int ADDR_SZ     = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [7:0]                      cmd_data,
  output logic                            text_wr_ena,
  output logic [7:0]                      text_wr_data,
  output logic [ADDR_SZ-1:0]              text_wr_addr,
  output logic [$clog2(TEXT_WIDTH)-1:0]   cursor_col,
  output logic [$clog2(TEXT_HEIGHT)-1:0]  cursor_row,
  output logic                            busy
);

  localparam int COL_W = $clog2(TEXT_WIDTH);
  localparam int ROW_W = $clog2(TEXT_HEIGHT);

  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(TEXT_WIDTH - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(TEXT_HEIGHT - 1);
  localparam logic [ADDR_SZ-1:0] LAST_ADDR = ADDR_SZ'(TEXT_LEN - 1);
  localparam logic [ADDR_SZ-1:0] ROW_STEP  = ADDR_SZ'(TEXT_WIDTH);

  localparam logic [1:0] OP_PUT_CHAR = 2'd0;
  localparam logic [1:0] OP_NEWLINE  = 2'd1;
  localparam logic [1:0] OP_CLEAR    = 2'd2;

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  state_t             state_q, state_d;
  logic               wr_ena_q, wr_ena_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [ADDR_SZ-1:0] wr_addr_q, wr_addr_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [ADDR_SZ-1:0] row_start_q, row_start_d;
  logic [ADDR_SZ-1:0] fill_cnt_q, fill_cnt_d;
  logic [7:0]         fill_data_q, fill_data_d;

  logic               accept;
  logic               do_put;
  logic               do_newline;
  logic               do_home;
  logic               start_clear;
  logic [7:0]         clear_fill;
  logic [ROW_W-1:0]   nl_row;
  logic [ADDR_SZ-1:0] nl_addr;

  always_comb begin
    state_d     = state_q;
    wr_ena_d    = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    row_start_d = row_start_q;
    fill_cnt_d  = fill_cnt_q;
    fill_data_d = fill_data_q;
    do_put      = 1'b0;
    do_newline  = 1'b0;
    do_home     = 1'b0;
    start_clear = 1'b0;
    clear_fill  = cmd_data;

    cmd_ready = (state_q == ST_IDLE) && !reset;
    accept    = cmd_valid && cmd_ready;

    // Start of the next row, tracked incrementally so no multiplier is needed.
    // The bottom row wraps back to the top because the screen never scrolls.
    if (row_q == LAST_ROW) begin
      nl_row  = '0;
      nl_addr = '0;
    end else begin
      nl_row  = row_q + ROW_W'(1);
      nl_addr = row_start_q + ROW_STEP;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUT_CHAR: begin
`ifdef TEXT_CONSOLE_CTRL_ASCII_EN
              if (cmd_data == 8'h0A) begin
                do_newline = 1'b1;
              end else if (cmd_data == 8'h0D) begin
                col_d  = '0;
                addr_d = row_start_q;
              end else if (cmd_data == 8'h0C) begin
                start_clear = 1'b1;
                clear_fill  = 8'h20;
              end else begin
                do_put = 1'b1;
              end
`else
              do_put = 1'b1;
`endif
            end
            OP_NEWLINE: do_newline  = 1'b1;
            OP_CLEAR:   start_clear = 1'b1;
            default:    do_home     = 1'b1;
          endcase
        end
      end
      ST_FILL: begin
        // fill_cnt_q holds the address currently on the write port; the
        // first fill write was already registered when CLEAR was accepted.
        if (fill_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          do_home = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + ADDR_SZ'(1);
          wr_ena_d   = 1'b1;
          wr_addr_d  = fill_cnt_q + ADDR_SZ'(1);
          wr_data_d  = fill_data_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_put) begin
      wr_ena_d  = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = cmd_data;
      if (col_q == LAST_COL) begin
        col_d       = '0;
        row_d       = nl_row;
        addr_d      = nl_addr;
        row_start_d = nl_addr;
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_SZ'(1);
      end
    end

    if (do_newline) begin
      col_d       = '0;
      row_d       = nl_row;
      addr_d      = nl_addr;
      row_start_d = nl_addr;
    end

    if (do_home) begin
      col_d       = '0;
      row_d       = '0;
      addr_d      = '0;
      row_start_d = '0;
    end

    if (start_clear) begin
      state_d     = ST_FILL;
      fill_data_d = clear_fill;
      fill_cnt_d  = '0;
      wr_ena_d    = 1'b1;
      wr_addr_d   = '0;
      wr_data_d   = clear_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ena_q    <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      row_start_q <= '0;
      fill_cnt_q  <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ena_q    <= wr_ena_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign text_wr_ena  = wr_ena_q;
  assign text_wr_data = wr_data_q;
  assign text_wr_addr = wr_addr_q;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;
  assign busy         = (state_q == ST_FILL);

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Command-driven write controller for the text RAM write port of the text pixel generator.
- Accepts host commands over a valid/ready handshake from the SPI command decoder: put character, newline, home, clear-screen.
- Keeps a cursor position and issues one registered text RAM write per cycle.
- Clear-screen is a multi-cycle fill sequence that blocks new commands until it completes.

Parameters:
- TEXT_WIDTH, 60, characters per text row.
- TEXT_HEIGHT, 20, text rows per screen.
- TEXT_LEN, TEXT_WIDTH*TEXT_HEIGHT, total cells; must be ≤ 8192.
- ADDR_SZ, 13, width of the text RAM write address.

Ports:
- clk  in  1  system clock; also drives the text RAM write clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  0=PUT_CHAR, 1=NEWLINE, 2=CLEAR, 3=HOME.
- cmd_data  in  8  character for PUT_CHAR; fill character for CLEAR; ignored otherwise.
- text_wr_ena  out  1  one-cycle write strobe to the text RAM.
- text_wr_data  out  8  write data.
- text_wr_addr  out  ADDR_SZ  write address, equal to row*TEXT_WIDTH + col.
- cursor_col  out  $clog2(TEXT_WIDTH)  current cursor column.
- cursor_row  out  $clog2(TEXT_HEIGHT)  current cursor row.
- busy  out  1  high while a CLEAR fill is in progress.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset, effective at the next clk edge:
  - state=IDLE.
  - text_wr_ena=0, text_wr_data=0, text_wr_addr=0.
  - cursor_col=0, cursor_row=0, internal cursor_addr=0.
  - busy=0.
- cmd_ready = (state==IDLE) && !reset. It is combinational, so it is low in the reset cycle.
- A command is accepted on a clk edge where cmd_valid && cmd_ready. Unaccepted commands have no effect. The host must hold cmd_op and cmd_data stable until acceptance.
- All text_wr_* outputs are registered. A write caused by an accepted command appears the cycle after acceptance. text_wr_ena is high for exactly one cycle per write and 0 in every other cycle.
- Cursor state:
  - The controller keeps cursor_addr incrementally (no multiplier): cursor_addr = cursor_row*TEXT_WIDTH + cursor_col at all times.
  - Row start address is kept in a separate register and advanced by TEXT_WIDTH.
- PUT_CHAR:
  - Write cmd_data at cursor_addr, then advance the cursor.
  - Not at the last column: col+1, addr+1.
  - At the last column: col=0, row+1, addr+1.
  - At the last column of the last row: col=0, row=0, addr=0. The screen wraps; there is no scroll.
  - Back-to-back PUT_CHARs sustain one write per cycle.
- NEWLINE: no write. col=0, row+1, addr=row start+TEXT_WIDTH. From the last row: row=0, addr=0.
- HOME: no write. Cursor and row start set to 0.
- CLEAR:
  - On acceptance: latch cmd_data, go to state FILL, busy=1, cmd_ready=0.
  - FILL issues writes to addresses 0,1,…,TEXT_LEN-1 on consecutive cycles, TEXT_LEN writes in total. The first write appears the cycle after acceptance.
  - After the write to TEXT_LEN-1 is issued: state=IDLE, busy=0, cursor homed. cmd_ready is high in the cycle after the final write strobe.
- State machine:
  - IDLE → FILL on accepted CLEAR.
  - FILL → IDLE when fill counter == TEXT_LEN-1.
  - All other ops stay in IDLE.
- Reset during FILL: the fill is aborted immediately. No further writes occur. Full reset values apply.
- Widths:
  - Address arithmetic is ADDR_SZ bits.
  - Wrap comparisons use LAST_COL=TEXT_WIDTH-1 and LAST_ROW=TEXT_HEIGHT-1, sized to the counter widths.

Optional Feature:
- Macro: TEXT_CONSOLE_CTRL_ASCII_EN.
- When defined, PUT_CHAR interprets control codes:
  - cmd_data==8'h0A behaves exactly as NEWLINE; no write.
  - cmd_data==8'h0D sets col=0 and addr=row start, row unchanged; no write.
  - cmd_data==8'h0C behaves as CLEAR with fill 8'h20.
- When undefined, all 256 codes, including 0A, 0D and 0C, are written literally as glyphs. This matches the font's use of the full code page 437.

Test Plan:
- Reset, then PUT_CHAR 8'h41 → one cycle later: text_wr_ena=1, addr=0, data=8'h41. Then cursor_col=1, cursor_row=0.
- 60 back-to-back PUT_CHARs from home → writes on 60 consecutive cycles, addr 0..59. Cursor ends at col=0, row=1; next PUT_CHAR writes addr 60.
- HOME, 3 PUT_CHARs, NEWLINE, PUT_CHAR 8'h42 → the NEWLINE produces no write strobe; the 8'h42 write is at addr 60. Cursor col=1, row=1.
- Cursor at row 19 col 59, PUT_CHAR 8'h5A → write at addr 1199. Cursor wraps to col=0, row=0.
- CLEAR data 8'h20 → busy=1 and cmd_ready=0 for 1200 cycles; writes addr 0..1199, all data 8'h20. Then cmd_ready=1 and cursor is (0,0). A cmd_valid held during the fill is accepted only afterward.
- CLEAR, reset asserted at fill write 500 → no writes after reset, busy=0, cursor (0,0). With ASCII_EN defined, PUT_CHAR 8'h0A from col 5 row 2 → no write; col 0, row 3.
